// File: rtl/mult_add_seq_if.sv
// Operand/result stream bundle for mult_add_seq: operand pair in, sum of products out.
interface mult_add_seq_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NPAIRS = 4
) ();
  localparam int unsigned ACC_W = 2 * WIDTH + $clog2(NPAIRS);
  localparam int unsigned CNT_W = $clog2(NPAIRS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/mult_add_seq.sv
// Time-multiplexed sum-of-products: one pair per cycle, result after NPAIRS pairs or in_last.
// Define MULT_ADD_SIGNED_EN to treat operands and result as two's complement.
module mult_add_seq #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NPAIRS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  mult_add_seq_if.slave bus
);
  localparam int unsigned ACC_W = 2 * WIDTH + $clog2(NPAIRS);
  localparam int unsigned CNT_W = $clog2(NPAIRS + 1);
  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned PadW  = ACC_W - ProdW;

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic [CNT_W-1:0] out_count_q;

  logic             in_ready;
  logic             in_fire;
  logic             out_fire;
  logic             last_pair;
  logic [ProdW-1:0] prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_next;

`ifdef MULT_ADD_SIGNED_EN
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  assign a_s      = bus.in_a;
  assign b_s      = bus.in_b;
  // Low ProdW bits of the product of sign-extended operands are the exact signed product.
  assign prod     = ProdW'(a_s) * ProdW'(b_s);
  assign prod_ext = {{PadW{prod[ProdW-1]}}, prod};
`else
  assign prod     = ProdW'(bus.in_a) * ProdW'(bus.in_b);
  assign prod_ext = {{PadW{1'b0}}, prod};
`endif

  assign in_fire   = bus.in_valid & in_ready;
  assign out_fire  = out_valid_q & bus.out_ready;
  assign last_pair = in_fire & ((count_q == CNT_W'(NPAIRS - 1)) | bus.in_last);
  assign acc_next  = (count_q == '0) ? prod_ext : acc_q + prod_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (last_pair) state_d = StHold;
      StHold:  if (out_fire)  state_d = StAccum;
      default: state_d = StAccum;
    endcase
    if (clr) state_d = StAccum;
  end

  // Decoded from registered state only: no path from out_ready to in_ready.
  always_comb begin
    in_ready = (state_q == StAccum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else if (clr) begin
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (in_fire) begin
        acc_q <= acc_next;
        if (last_pair) begin
          count_q     <= '0;
          out_sum_q   <= acc_next;
          out_count_q <= count_q + CNT_W'(1);
          out_valid_q <= 1'b1;
        end else begin
          count_q <= count_q + CNT_W'(1);
        end
      end
      if (out_fire) out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_mult_add_seq.sv
// Directed self-checking bench for mult_add_seq (WIDTH=4, NPAIRS=4).
module tb_mult_add_seq;
  localparam int unsigned WIDTH  = 4;
  localparam int unsigned NPAIRS = 4;
  localparam int unsigned ACC_W  = 10;
  localparam int unsigned CNT_W  = 3;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  mult_add_seq_if #(.WIDTH(WIDTH), .NPAIRS(NPAIRS)) bus ();

  mult_add_seq #(.WIDTH(WIDTH), .NPAIRS(NPAIRS)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus at the falling edge; return 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic last, input logic ordy, input logic c, input logic r);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_last   = last;
    bus.out_ready = ordy;
    clr           = c;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_sum !== 10'd0) begin
      n_fail++; $display("FAIL reset_out_sum got %0d want 0", bus.out_sum);
    end
    n_checks++;
    if (bus.out_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_out_count got %0d want 0", bus.out_count);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_normal();
    step(1'b1, 4'd3, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL normal_mid valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    step(1'b1, 4'd2, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd15, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL normal_done valid=%b ready=%b want 1/0", bus.out_valid, bus.in_ready);
    end
    n_checks++;
    if (bus.out_sum !== 10'd255 || bus.out_count !== 3'd4) begin
      n_fail++; $display("FAIL normal_sum got %0d/%0d want 255/4", bus.out_sum, bus.out_count);
    end
    step(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL normal_drain valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    // The pair presented during HOLD must not have been taken.
    step(1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_sum !== 10'd4 || bus.out_count !== 3'd1) begin
      n_fail++; $display("FAIL normal_first_last got %0d/%0d want 4/1", bus.out_sum, bus.out_count);
    end
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_max();
    for (int i = 0; i < 4; i++) step(1'b1, 4'd15, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'h384 || bus.out_count !== 3'd4) begin
      n_fail++;
      $display("FAIL max_sum got v=%b %0d/%0d want 1 900/4", bus.out_valid, bus.out_sum,
               bus.out_count);
    end
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_early();
    step(1'b1, 4'd2, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    // in_last with no transfer is ignored; gap holds the partial sum.
    step(1'b0, 4'd9, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL early_gap_last got valid=%b want 0", bus.out_valid);
    end
    step(1'b1, 4'd4, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd26 || bus.out_count !== 3'd2) begin
      n_fail++;
      $display("FAIL early_sum got v=%b %0d/%0d want 1 26/2", bus.out_valid, bus.out_sum,
               bus.out_count);
    end
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_sum !== 10'd4 || bus.out_count !== 3'd4) begin
      n_fail++; $display("FAIL early_next got %0d/%0d want 4/4", bus.out_sum, bus.out_count);
    end
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    step(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd7, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== 10'd100 ||
          bus.out_count !== 3'd4) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d v=%b rdy=%b %0d/%0d want 1 0 100/4", i, bus.out_valid,
                 bus.in_ready, bus.out_sum, bus.out_count);
      end
    end
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    step(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_sum !== 10'd9 || bus.out_count !== 3'd1) begin
      n_fail++; $display("FAIL bp_no_consume got %0d/%0d want 9/1", bus.out_sum, bus.out_count);
    end
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    step(1'b1, 4'd7, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd7, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd9, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_clr valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_sum !== 10'd4 || bus.out_count !== 3'd4) begin
      n_fail++; $display("FAIL abort_clr_sum got %0d/%0d want 4/4", bus.out_sum, bus.out_count);
    end
    // clr beats an output transfer in HOLD; out_sum keeps its stale value.
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== 10'd4) begin
      n_fail++; $display("FAIL abort_hold_clr v=%b sum=%0d want 0/4", bus.out_valid, bus.out_sum);
    end
    step(1'b1, 4'd7, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd7, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd9, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_sum !== 10'd0) begin
      n_fail++;
      $display("FAIL abort_rst v=%b rdy=%b sum=%0d want 0 1 0", bus.out_valid, bus.in_ready,
               bus.out_sum);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_sum !== 10'd4 || bus.out_count !== 3'd4) begin
      n_fail++; $display("FAIL abort_rst_sum got %0d/%0d want 4/4", bus.out_sum, bus.out_count);
    end
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_signed();
    for (int i = 0; i < 4; i++) step(1'b1, 4'h8, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_sum !== 10'h100 || bus.out_count !== 3'd4) begin
      n_fail++; $display("FAIL signed_max got %h/%0d want 100/4", bus.out_sum, bus.out_count);
    end
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'h8, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_sum !== 10'h320 || bus.out_count !== 3'd4) begin
      n_fail++; $display("FAIL signed_min got %h/%0d want 320/4", bus.out_sum, bus.out_count);
    end
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'hF, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'h1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd0 || bus.out_count !== 3'd2) begin
      n_fail++;
      $display("FAIL signed_zero got v=%b %h/%0d want 1 000/2", bus.out_valid, bus.out_sum,
               bus.out_count);
    end
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
`ifdef MULT_ADD_SIGNED_EN
    test_signed();
    test_abort();
`else
    test_normal();
    test_max();
    test_early();
    test_backpressure();
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_add_seq.md
Name: mult_add_seq

Overview:
- Parametrised, time-multiplexed sum-of-products unit. Successor to the fixed 4-pair, 4-bit combinational multiply-add tree.
- Accepts one operand pair per cycle over a valid/ready stream and accumulates the products.
- Emits the registered sum after NPAIRS pairs, or earlier on in_last.
- Holds the result under output backpressure; sits between an operand source and a result consumer in the datapath labs.

Parameters:
- WIDTH, 4, operand width in bits (>=2)
- NPAIRS, 4, max pairs per result (>=2)
- ACC_W, 2*WIDTH+$clog2(NPAIRS), result/accumulator width (derived; do not override)
- CNT_W, $clog2(NPAIRS+1), width of out_count (derived)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- clr  input  1  synchronous abort of the current sum
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts a pair this cycle
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier
- in_last  input  1  qualifies the pair as the final one of this sum
- out_valid  output  1  result present
- out_ready  input  1  consumer takes the result
- out_sum  output  ACC_W  sum of products
- out_count  output  CNT_W  number of pairs in out_sum

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state=ACCUM, acc=0, count=0, out_valid=0, out_sum=0, out_count=0. in_ready=1 after reset.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- in_ready = (state==ACCUM). It is decoded from registered state only, with no combinational path from out_ready.
- FSM, state ACCUM:
  - On an input transfer with count==0: acc <= a*b.
  - Otherwise: acc <= acc + a*b.
  - Each transfer: count <= count+1.
  - If (count==NPAIRS-1) or in_last on that transfer: out_sum <= acc_next, out_count <= count+1, out_valid <= 1, count <= 0, state <= HOLD.
- FSM, state HOLD:
  - in_ready=0; out_sum and out_count stable.
  - On an output transfer: out_valid <= 0, state <= ACCUM.
  - in_ready rises the cycle after the output transfer, so there is no same-cycle pass-through.
- Latency: out_valid asserts the cycle after the last pair is accepted. Throughput is NPAIRS pairs per NPAIRS+1 cycles with out_ready held high.
- Arithmetic:
  - Products are full 2*WIDTH bits, zero-extended to ACC_W.
  - ACC_W is sized so the worst case NPAIRS*(2^WIDTH-1)^2 never overflows. No saturation or wrap can occur.
- in_valid low in ACCUM: acc and count hold, so gaps between pairs are allowed.
- clr (any state): next cycle acc=0, count=0, out_valid=0, state=ACCUM. out_sum and out_count keep their old values but are invalid.
  - clr wins over a simultaneous input transfer, and that pair is dropped.
  - clr wins over a simultaneous output transfer.
- rst has priority over clr. rst mid-accumulation discards the partial sum.
- in_last on the first pair gives out_count=1, out_sum=a*b.
- in_last is ignored when no transfer occurs.

Optional Feature:
- Macro: MULT_ADD_SIGNED_EN
- Defined:
  - in_a and in_b are two's complement.
  - Products are signed 2*WIDTH bits, sign-extended to ACC_W.
  - out_sum is a two's-complement ACC_W value. The worst case NPAIRS*2^(2*WIDTH-2) still fits.
- Undefined: all operands and results unsigned, as above. Ports and timing are identical either way.

Test Plan:
- All tests use WIDTH=4, NPAIRS=4.
- Normal sum: rst 2 cycles, then pairs (3,5),(2,7),(15,15),(1,1) back-to-back, out_ready=1 -> out_valid one cycle after 4th pair, out_sum=255, out_count=4, in_ready low exactly 1 cycle.
- Max value: four pairs (15,15) -> out_sum=900 (10'h384), no overflow; reset check: all outputs 0 and in_ready=1 after rst.
- Early termination: (2,3), then (4,5) with in_last=1 -> out_sum=26, out_count=2; next sum (1,1)x4 starts from 0 -> out_sum=4.
- Backpressure: complete a sum, hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid stays 1, out_sum stable, in_ready=0, no pair consumed. Raise out_ready -> out_valid=0 next cycle.
- Abort: two pairs (7,7),(7,7) accepted, then clr together with in_valid (9,9), then (1,1)x4 -> out_sum=4, out_count=4. Also assert rst mid-sum -> same clean restart.
- Signed (MULT_ADD_SIGNED_EN): (-8,-8)x4 -> out_sum=256; (-8,7)x4 -> out_sum=-224 (10'h320); (-1,1),(1,1) with in_last -> out_sum=0, out_count=2.
